// File: rtl/elevator_ctrl_scan.sv
// N-floor SCAN elevator controller with travel/door timers and emergency stop.
// Optional ELEV_DOOR_OBSTRUCT_EN adds a door_obstruct input that holds the door open.
module elevator_ctrl_scan #(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int FLOOR_W       = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                emergency_stop,
`ifdef ELEV_DOOR_OBSTRUCT_EN
  input  logic                door_obstruct,
`endif
  input  logic [N_FLOORS-1:0] floor_request,
  output logic [2:0]          state,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic                door_open,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    EMERGENCY = 3'd4
  } state_t;

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  cur_q, cur_d, nxt;
  logic                dir_q, dir_d;
  logic                door_open_q, door_open_d;
  logic [N_FLOORS-1:0] pend_q, pend_d, req, clr;
  logic [TW-1:0]       trav_q, trav_d;
  logic [DW-1:0]       door_q, door_d;
  logic                hold_door;

  function automatic logic any_ahead(input logic [N_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f, input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if (v[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
    return r;
  endfunction

`ifdef ELEV_DOOR_OBSTRUCT_EN
  assign hold_door = door_obstruct;
`else
  assign hold_door = 1'b0;
`endif

  always_comb begin
    req         = pend_q | floor_request;
    clr         = '0;
    state_d     = state_q;
    cur_d       = cur_q;
    dir_d       = dir_q;
    trav_d      = trav_q;
    door_d      = door_q;
    nxt         = cur_q;
    if (emergency_stop) begin
      state_d = EMERGENCY;
      trav_d  = '0;
      door_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          trav_d = '0;
          door_d = '0;
          if (pend_q[cur_q]) begin
            state_d    = DOOR_OPEN;
            clr[cur_q] = 1'b1;
          end else if (dir_q && any_ahead(pend_q, cur_q, 1'b1)) begin
            state_d = MOVE_UP;
          end else if (any_ahead(pend_q, cur_q, 1'b0)) begin
            state_d = MOVE_DOWN;
            dir_d   = 1'b0;
          end else if (any_ahead(pend_q, cur_q, 1'b1)) begin
            state_d = MOVE_UP;
            dir_d   = 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (trav_q == T_LAST) begin
            trav_d = '0;
            nxt    = (state_q == MOVE_UP) ? cur_q + 1'b1 : cur_q - 1'b1;
            cur_d  = nxt;
            // A request for the arrival floor latched this same edge still stops the car.
            if (req[nxt]) begin
              state_d  = DOOR_OPEN;
              door_d   = '0;
              clr[nxt] = 1'b1;
            end else if (!any_ahead(req, nxt, state_q == MOVE_UP)) begin
              state_d = IDLE;
            end
          end else begin
            trav_d = trav_q + 1'b1;
          end
        end
        DOOR_OPEN: begin
          clr[cur_q] = 1'b1;
          if (floor_request[cur_q] || hold_door) begin
            door_d = '0;
          end else if (door_q == D_LAST) begin
            door_d  = '0;
            state_d = IDLE;
          end else begin
            door_d = door_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    pend_d      = req & ~clr;
    door_open_d = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      dir_q       <= 1'b1;
      door_open_q <= 1'b0;
      pend_q      <= '0;
      trav_q      <= '0;
      door_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      dir_q       <= dir_d;
      door_open_q <= door_open_d;
      pend_q      <= pend_d;
      trav_q      <= trav_d;
      door_q      <= door_d;
    end
  end

  assign state         = state_q;
  assign current_floor = cur_q;
  assign door_open     = door_open_q;
  assign dir_up        = dir_q;
  assign pending       = pend_q;

endmodule

// File: tb/tb_elevator_ctrl_scan.sv
// Random-stimulus bench for elevator_ctrl_scan against a timer-based behavioural model.
module tb_elevator_ctrl_scan;
  localparam int N = 4;
  localparam int T = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         emergency_stop = 1'b0;
  logic         door_obstruct = 1'b0;
  logic [N-1:0] floor_request = '0;
  logic [2:0]   state;
  logic [1:0]   current_floor;
  logic         door_open, dir_up;
  logic [N-1:0] pending;

  int total = 0;
  int bad = 0;

  elevator_ctrl_scan #(.N_FLOORS(N), .TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .emergency_stop(emergency_stop),
`ifdef ELEV_DOOR_OBSTRUCT_EN
    .door_obstruct(door_obstruct),
`endif
    .floor_request(floor_request), .state(state), .current_floor(current_floor),
    .door_open(door_open), .dir_up(dir_up), .pending(pending));

  always #5 clk = ~clk;

  // Model: state code, floor, direction, pending, cycles left in travel / door interval.
  int           mst = 0, mfl = 0, tleft = 0, dleft = 0;
  bit           mdir = 1'b1;
  bit [N-1:0]   mpend = '0;

  function automatic bit ahead(input bit [N-1:0] v, input int f, input bit up);
    for (int i = 0; i < N; i++)
      if (v[i] && (up ? i > f : i < f)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit [N-1:0] rq, cl;
    bit obs;
`ifdef ELEV_DOOR_OBSTRUCT_EN
    obs = door_obstruct;
`else
    obs = 1'b0;
`endif
    rq = mpend | floor_request;
    cl = '0;
    if (rst) begin
      mst = 0; mfl = 0; mdir = 1'b1; mpend = '0;
    end else begin
      if (emergency_stop) mst = 4;
      else case (mst)
        0: begin
          if (mpend[mfl]) begin mst = 3; dleft = D; cl[mfl] = 1'b1; end
          else if (mdir && ahead(mpend, mfl, 1'b1)) begin mst = 1; tleft = T; end
          else if (ahead(mpend, mfl, 1'b0)) begin mst = 2; mdir = 1'b0; tleft = T; end
          else if (ahead(mpend, mfl, 1'b1)) begin mst = 1; mdir = 1'b1; tleft = T; end
        end
        1, 2: begin
          tleft--;
          if (tleft == 0) begin
            mfl = (mst == 1) ? mfl + 1 : mfl - 1;
            if (rq[mfl]) begin mst = 3; dleft = D; cl[mfl] = 1'b1; end
            else if (ahead(rq, mfl, mst == 1)) tleft = T;
            else mst = 0;
          end
        end
        3: begin
          cl[mfl] = 1'b1;
          if (floor_request[mfl] || obs) dleft = D;
          else begin
            dleft--;
            if (dleft == 0) mst = 0;
          end
        end
        default: mst = 0;
      endcase
      mpend = rq & ~cl;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_state", int'(state), mst);
      chk("model_floor", int'(current_floor), mfl);
      chk("model_door", int'(door_open), int'(mst == 3));
      chk("model_dir", int'(dir_up), int'(mdir));
      chk("model_pending", int'(pending), int'(mpend));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int est_left, obs_left;
    step(2);
    chk("rst_state", int'(state), 0);
    chk("rst_floor", int'(current_floor), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_pending", int'(pending), 0);
    rst = 1'b0;
    step(1);
    // Request top floor: one idle latch cycle, then three 4-cycle hops, then 3-cycle door.
    floor_request = 4'b1000;
    step(1);
    floor_request = '0;
    chk("s1_latched", int'(pending), 8);
    chk("s1_still_idle", int'(state), 0);
    step(1);
    chk("s1_move_up", int'(state), 1);
    step(4);
    chk("s1_floor1", int'(current_floor), 1);
    step(4);
    chk("s1_floor2", int'(current_floor), 2);
    step(4);
    chk("s1_floor3", int'(current_floor), 3);
    chk("s1_door_on", int'(door_open), 1);
    step(2);
    chk("s1_door_3rd", int'(door_open), 1);
    step(1);
    chk("s1_door_off", int'(door_open), 0);
    chk("s1_idle", int'(state), 0);
    chk("s1_pend_clr", int'(pending), 0);
    // Same-floor request, then re-request during the open interval.
    floor_request = 4'b1000;
    step(1);
    floor_request = '0;
    step(1);
    chk("s2_door_open", int'(state), 3);
    floor_request = 4'b1000;
    step(1);
    floor_request = '0;
    chk("s2_rereq_pend", int'(pending), 0);
    step(2);
    chk("s2_door_ext", int'(door_open), 1);
    step(1);
    chk("s2_door_done", int'(door_open), 0);

    est_left = 0;
    obs_left = 0;
    for (int i = 0; i < 5000; i++) begin
      floor_request = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if (est_left == 0 && $urandom_range(0, 150) == 0) est_left = $urandom_range(1, 4);
      emergency_stop = (est_left != 0);
      if (est_left != 0) est_left--;
      if (obs_left == 0 && $urandom_range(0, 60) == 0) obs_left = $urandom_range(1, 6);
      door_obstruct = (obs_left != 0);
      if (obs_left != 0) obs_left--;
      rst = (i == 2500 || i == 2501);
      step(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
